ipv4_header_rx: RTL and testbench

Parametrised IPv4 receive stage that replaces the plain IP/ARP dispatcher on the Ethernet receive path. It consumes the layer‑3 portion of a frame as an N‑bit beat stream and sorts frames by ethertype. For IPv4 frames it validates version, IHL, total length and header checksum, skips options, and filters on destination address. Accepted frames have their header fields registered and only their payload bytes forwarded downstream, trimmed to total length; Ethernet padding and FCS never reach the transport layer.

---
 rtl/ipv4_header_rx.sv | 200 ++++++++++++++++++++
 tb/tb_ipv4_header_rx.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipv4_header_rx.sv
// IPv4 receive stage: sorts L3 beats by ethertype, validates and filters the IPv4 header,
// forwards only payload trimmed to total length. Define IPV4_CHECKSUM_EN to check the header checksum.
module ipv4_header_rx #(
    parameter int          N     = 2,
    parameter logic [31:0] MY_IP = 32'hC0A8_0102
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         axiiv,
    input  logic [N-1:0] axiid,
    input  logic         ethertype_in,
    output logic         axiov,
    output logic [N-1:0] axiod,
    output logic [31:0]  src_ip_out,
    output logic [31:0]  dst_ip_out,
    output logic [7:0]   protocol_out,
    output logic [15:0]  packet_length_out,
    output logic         header_valid_out,
    output logic         err_out
);

    localparam int         B         = 8 / N;
    localparam logic [2:0] LAST_BEAT = 3'(B - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HEADER  = 3'd1;
    localparam logic [2:0] S_OPTIONS = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_DROP    = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  r_beat;
    logic [15:0] r_bcnt;
    logic [15:0] r_tl;
    logic [3:0]  r_ihl;
    logic [7:0]  r_proto;
    logic [31:0] r_src;
    logic [31:0] r_dst;

    logic [7:0]  w_byte;
    logic        w_hdr_state;
    logic        w_proc;
    logic        w_byte_done;
    logic        w_hdr_byte;
    logic        w_hdr_end;
    logic        w_fwd;
    logic        w_csum_ok;
    logic        w_dst_ok;
    logic        w_tl_short;
    logic [15:0] w_hdr_len;
    logic [31:0] w_dst_next;
    logic [31:0] w_dst_full;

    // Bytes arrive LSB beat first, so each new beat lands on top of the older ones.
    generate
        if (N == 8) begin : g_byte8
            assign w_byte = axiid;
        end else begin : g_shift
            logic [7-N:0] r_shift;
            assign w_byte = {axiid, r_shift};
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_shift <= '0;
                end else if (w_proc) begin
                    r_shift <= w_byte[7:N];
                end
            end
        end
    endgenerate

    assign w_hdr_state = (r_state == S_HEADER) || (r_state == S_OPTIONS);
    assign w_proc      = axiiv && (((r_state == S_IDLE) && !ethertype_in) ||
                                   w_hdr_state || (r_state == S_PAYLOAD));
    assign w_byte_done = w_proc && (r_beat == LAST_BEAT);
    assign w_hdr_byte  = w_byte_done && ((r_state == S_IDLE) || (r_state == S_HEADER));
    assign w_hdr_len   = {10'd0, r_ihl, 2'b00};
    assign w_hdr_end   = w_byte_done && w_hdr_state && (r_bcnt >= 16'd19) &&
                         (r_bcnt == w_hdr_len - 16'd1);
    // With IHL=5 the last destination byte is still in flight at the decision point.
    assign w_dst_next  = {r_dst[23:0], w_byte};
    assign w_dst_full  = (r_bcnt == 16'd19) ? w_dst_next : r_dst;
    assign w_dst_ok    = (w_dst_full == MY_IP) || (w_dst_full == '1);
    assign w_tl_short  = r_tl < w_hdr_len;
    assign w_fwd       = axiiv && (r_state == S_PAYLOAD) && (r_bcnt < r_tl);

`ifdef IPV4_CHECKSUM_EN
    logic [7:0]  r_hi;
    logic [15:0] r_csum;
    logic [16:0] w_sum;
    logic [15:0] w_csum_next;

    assign w_sum       = {1'b0, r_csum} + {1'b0, r_hi, w_byte};
    assign w_csum_next = w_sum[15:0] + {15'd0, w_sum[16]};
    assign w_csum_ok   = (w_csum_next == 16'hFFFF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi   <= '0;
            r_csum <= '0;
        end else if (!axiiv) begin
            r_hi   <= '0;
            r_csum <= '0;
        end else if (w_byte_done && (r_state != S_PAYLOAD)) begin
            if (!r_bcnt[0]) begin
                r_hi <= w_byte;
            end else begin
                r_csum <= w_csum_next;
            end
        end
    end
`else
    assign w_csum_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state           <= S_IDLE;
            r_beat            <= '0;
            r_bcnt            <= '0;
            r_tl              <= '0;
            r_ihl             <= '0;
            r_proto           <= '0;
            r_src             <= '0;
            r_dst             <= '0;
            axiov             <= 1'b0;
            axiod             <= '0;
            src_ip_out        <= '0;
            dst_ip_out        <= '0;
            protocol_out      <= '0;
            packet_length_out <= '0;
            header_valid_out  <= 1'b0;
            err_out           <= 1'b0;
        end else begin
            header_valid_out <= 1'b0;
            err_out          <= 1'b0;
            axiov            <= w_fwd;
            axiod            <= w_fwd ? axiid : '0;

            if (!axiiv) begin
                r_state <= S_IDLE;
                r_beat  <= '0;
                r_bcnt  <= '0;
                err_out <= w_hdr_state || ((r_state == S_PAYLOAD) && (r_bcnt < r_tl));
            end else begin
                if (w_proc) begin
                    r_beat <= (r_beat == LAST_BEAT) ? 3'd0 : r_beat + 3'd1;
                end
                if (w_byte_done) begin
                    r_bcnt <= r_bcnt + 16'd1;
                end

                if (w_hdr_byte) begin
                    case (r_bcnt)
                        16'd2:  r_tl[15:8] <= w_byte;
                        16'd3:  r_tl[7:0]  <= w_byte;
                        16'd9:  r_proto    <= w_byte;
                        16'd12, 16'd13, 16'd14, 16'd15: r_src <= {r_src[23:0], w_byte};
                        16'd16, 16'd17, 16'd18, 16'd19: r_dst <= w_dst_next;
                        default: ;
                    endcase
                end

                case (r_state)
                    S_IDLE:    r_state <= ethertype_in ? S_DROP : S_HEADER;
                    S_HEADER:  if (w_byte_done && (r_bcnt == 16'd19) && (r_ihl > 4'd5))
                                   r_state <= S_OPTIONS;
                    S_PAYLOAD: if (!w_fwd || (w_byte_done && (r_bcnt + 16'd1 == r_tl)))
                                   r_state <= S_DROP;
                    default: ;
                endcase

                if (w_hdr_byte && (r_bcnt == 16'd0)) begin
                    r_ihl <= w_byte[3:0];
                    if ((w_byte[7:4] != 4'd4) || (w_byte[3:0] < 4'd5)) begin
                        err_out <= 1'b1;
                        r_state <= S_DROP;
                    end
                end

                // Error checks outrank the address filter so a corrupt header never passes silently.
                if (w_hdr_end) begin
                    if (w_tl_short || !w_csum_ok) begin
                        err_out <= 1'b1;
                        r_state <= S_DROP;
                    end else if (!w_dst_ok) begin
                        r_state <= S_DROP;
                    end else begin
                        r_state           <= S_PAYLOAD;
                        header_valid_out  <= 1'b1;
                        src_ip_out        <= r_src;
                        dst_ip_out        <= w_dst_full;
                        protocol_out      <= r_proto;
                        packet_length_out <= r_tl;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ipv4_header_rx.sv
// Scoreboard bench for ipv4_header_rx: a frame-level reference model queues expected
// headers, payload beats and errors; a monitor consumes them as the DUT produces outputs.
module tb_ipv4_header_rx;

    localparam int          N     = 2;
    localparam logic [31:0] MY_IP = 32'hC0A8_0102;
`ifdef IPV4_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         axiiv;
    logic [N-1:0] axiid;
    logic         ethertype_in;
    logic         axiov;
    logic [N-1:0] axiod;
    logic [31:0]  src_ip_out;
    logic [31:0]  dst_ip_out;
    logic [7:0]   protocol_out;
    logic [15:0]  packet_length_out;
    logic         header_valid_out;
    logic         err_out;

    always #5 clk = ~clk;

    ipv4_header_rx #(.N(N), .MY_IP(MY_IP)) dut (
        .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid), .ethertype_in(ethertype_in),
        .axiov(axiov), .axiod(axiod), .src_ip_out(src_ip_out), .dst_ip_out(dst_ip_out),
        .protocol_out(protocol_out), .packet_length_out(packet_length_out),
        .header_valid_out(header_valid_out), .err_out(err_out)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_beats  = 0;

    logic [7:0]  fr[$];
    logic [1:0]  exp_beats[$];
    logic [87:0] exp_hdr[$];
    int          exp_err = 0;
    logic [87:0] last_hdr = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ones_sum(input int nbytes);
        logic [31:0] s;
        s = 0;
        for (int i = 0; i < nbytes; i += 2) s += {16'd0, fr[i], fr[i+1]};
        while (s[31:16] != 0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        return s[15:0];
    endfunction

    task automatic build(input logic [3:0] ver, input logic [3:0] ihl, input logic [15:0] tl,
                         input logic [7:0] proto, input logic [31:0] src, input logic [31:0] dst,
                         input int npay, input int npad, input bit bad);
        int hl;
        logic [15:0] cs;
        hl = (ihl < 5) ? 20 : int'(ihl) * 4;
        fr.delete();
        fr.push_back({ver, ihl});
        fr.push_back(8'h00);
        fr.push_back(tl[15:8]);
        fr.push_back(tl[7:0]);
        for (int i = 4; i < 8; i++) fr.push_back(8'($urandom_range(0, 255)));
        fr.push_back(8'd64);
        fr.push_back(proto);
        fr.push_back(8'h00);
        fr.push_back(8'h00);
        for (int i = 3; i >= 0; i--) fr.push_back(src[8*i +: 8]);
        for (int i = 3; i >= 0; i--) fr.push_back(dst[8*i +: 8]);
        for (int i = 20; i < hl; i++) fr.push_back(8'($urandom_range(0, 255)));
        cs = ~ones_sum(hl);
        fr[10] = cs[15:8];
        fr[11] = cs[7:0];
        if (bad) fr[10] = fr[10] ^ 8'h01;
        for (int i = 0; i < npay + npad; i++) fr.push_back(8'($urandom_range(0, 255)));
    endtask

    // Frame-level rules: what one whole frame should produce, independent of beat timing.
    function automatic void model(input bit eth);
        int len, hl, stop;
        logic [15:0] tl;
        logic [31:0] dst, src;
        len = fr.size();
        if (eth) return;
        if (fr[0][7:4] != 4'd4 || fr[0][3:0] < 4'd5) begin exp_err++; return; end
        hl = int'(fr[0][3:0]) * 4;
        if (len < hl) begin exp_err++; return; end
        tl = {fr[2], fr[3]};
        if (int'(tl) < hl) begin exp_err++; return; end
        if (CSUM_EN && ones_sum(hl) != 16'hFFFF) begin exp_err++; return; end
        src = {fr[12], fr[13], fr[14], fr[15]};
        dst = {fr[16], fr[17], fr[18], fr[19]};
        if (dst != MY_IP && dst != 32'hFFFF_FFFF) return;
        last_hdr = {src, dst, fr[9], tl};
        exp_hdr.push_back(last_hdr);
        stop = (int'(tl) < len) ? int'(tl) : len;
        for (int i = hl; i < stop; i++)
            for (int b = 0; b < 4; b++) exp_beats.push_back(fr[i][2*b +: 2]);
        if (len < int'(tl)) exp_err++;
    endfunction

    task automatic send(input bit eth, input int nfirst, input int nbytes);
        for (int i = nfirst; i < nbytes; i++)
            for (int b = 0; b < 4; b++) begin
                @(negedge clk);
                axiiv = 1'b1;
                ethertype_in = eth;
                axiid = fr[i][2*b +: 2];
            end
    endtask

    task automatic end_frame();
        @(negedge clk);
        axiiv = 1'b0;
        axiid = '0;
    endtask

    task automatic run(input bit eth);
        model(eth);
        send(eth, 0, fr.size());
        end_frame();
    endtask

    task automatic drain(input string tag);
        repeat (6) @(negedge clk);
        check({tag, "_beats_left"}, exp_beats.size(), 0);
        check({tag, "_hdr_left"}, exp_hdr.size(), 0);
        check({tag, "_err_left"}, exp_err, 0);
        check({tag, "_hold_hdr"}, {src_ip_out, dst_ip_out, protocol_out, packet_length_out}, last_hdr);
        exp_beats.delete();
        exp_hdr.delete();
        exp_err = 0;
    endtask

    initial begin
        logic [1:0]  eb;
        logic [87:0] eh;
        forever begin
            @(posedge clk);
            #1;
            if (axiov) begin
                n_beats++;
                if (exp_beats.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_axiov: got beat %0h, required none", axiod);
                end else begin
                    eb = exp_beats.pop_front();
                    check("axiod", axiod, eb);
                end
            end
            if (header_valid_out && err_out) begin
                n_checks++; n_fail++;
                $display("FAIL hv_err_overlap: got both pulses high, required exclusive");
            end
            if (header_valid_out) begin
                if (exp_hdr.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_header: got src %0h dst %0h, required none", src_ip_out, dst_ip_out);
                end else begin
                    eh = exp_hdr.pop_front();
                    check("header", {src_ip_out, dst_ip_out, protocol_out, packet_length_out}, eh);
                end
            end
            if (err_out) begin
                if (exp_err == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_err: got err_out 1, required 0");
                end else begin
                    exp_err--;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        n_fail++;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        int b0, hl, npay, ntl, cut;
        bit eth, bad;
        logic [3:0] ver, ihl;
        logic [31:0] dst;
        logic [15:0] tl;

        rst = 1'b1; axiiv = 1'b0; axiid = '0; ethertype_in = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {axiov, axiod, src_ip_out, dst_ip_out, protocol_out,
              packet_length_out, header_valid_out, err_out}, '0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Valid UDP
        build(4'd4, 4'd5, 16'd28, 8'h11, 32'hC0A8_0101, MY_IP, 8, 18, 1'b0);
        b0 = n_beats;
        run(1'b0);
        drain("udp");
        check("udp_src", src_ip_out, 32'hC0A8_0101);
        check("udp_proto", protocol_out, 8'h11);
        check("udp_len", packet_length_out, 16'd28);
        check("udp_nbeats", n_beats - b0, 32);

        // Bad checksum
        build(4'd4, 4'd5, 16'd28, 8'h11, 32'hC0A8_0101, MY_IP, 8, 18, 1'b1);
        b0 = n_beats;
        run(1'b0);
        drain("badcsum");
        check("badcsum_nbeats", n_beats - b0, CSUM_EN ? 0 : 32);

        // Options
        build(4'd4, 4'd6, 16'd32, 8'h06, 32'h0A00_0001, MY_IP, 8, 10, 1'b0);
        b0 = n_beats;
        run(1'b0);
        drain("options");
        check("options_nbeats", n_beats - b0, 32);

        // Address filter: other host dropped, broadcast accepted
        build(4'd4, 4'd5, 16'd30, 8'h11, 32'h0102_0304, 32'h0A00_0005, 10, 4, 1'b0);
        run(1'b0);
        drain("filter_other");
        build(4'd4, 4'd5, 16'd24, 8'h11, 32'h0102_0304, 32'hFFFF_FFFF, 4, 4, 1'b0);
        run(1'b0);
        drain("filter_bcast");
        check("bcast_dst", dst_ip_out, 32'hFFFF_FFFF);

        // Ethertype ARP, then version 6 with error timing at byte 0
        build(4'd4, 4'd5, 16'd28, 8'h11, 32'h0102_0304, MY_IP, 8, 4, 1'b0);
        run(1'b1);
        drain("arp");
        build(4'd6, 4'd5, 16'd28, 8'h11, 32'h0102_0304, MY_IP, 8, 4, 1'b0);
        model(1'b0);
        send(1'b0, 0, 1);
        @(posedge clk); #2;
        check("ver6_err_timing", err_out, 1'b1);
        send(1'b0, 1, fr.size());
        end_frame();
        drain("ver6");

        // Truncation after 3 payload bytes, truncation inside header, short total length, zero payload
        build(4'd4, 4'd5, 16'd28, 8'h11, 32'h0102_0304, MY_IP, 3, 0, 1'b0);
        run(1'b0);
        drain("trunc_pay");
        build(4'd4, 4'd5, 16'd28, 8'h11, 32'h0102_0304, MY_IP, 0, 0, 1'b0);
        while (fr.size() > 10) void'(fr.pop_back());
        run(1'b0);
        drain("trunc_hdr");
        build(4'd4, 4'd5, 16'd16, 8'h11, 32'h0102_0304, MY_IP, 4, 4, 1'b0);
        run(1'b0);
        drain("short_tl");
        build(4'd4, 4'd5, 16'd20, 8'h01, 32'h0102_0305, MY_IP, 0, 6, 1'b0);
        run(1'b0);
        drain("zero_pay");

        // Back-to-back with a single idle cycle
        build(4'd4, 4'd5, 16'd26, 8'h11, 32'h0505_0505, MY_IP, 6, 2, 1'b0);
        run(1'b0);
        build(4'd4, 4'd7, 16'd32, 8'h06, 32'h0606_0606, 32'hFFFF_FFFF, 4, 3, 1'b0);
        run(1'b0);
        drain("b2b");

        // Reset mid-payload; remainder arrives as an ARP-typed frame and is dropped
        build(4'd4, 4'd5, 16'd28, 8'h11, 32'h0707_0707, MY_IP, 8, 4, 1'b0);
        last_hdr = {32'h0707_0707, MY_IP, 8'h11, 16'd28};
        exp_hdr.push_back(last_hdr);
        for (int i = 20; i < 23; i++)
            for (int b = 0; b < 4; b++) exp_beats.push_back(fr[i][2*b +: 2]);
        send(1'b0, 0, 23);
        @(negedge clk);
        rst = 1'b1; ethertype_in = 1'b1; axiid = fr[23][1:0];
        #1;
        check("midreset_outputs", {axiov, axiod, src_ip_out, dst_ip_out, protocol_out,
              packet_length_out, header_valid_out, err_out}, '0);
        last_hdr = '0;
        @(negedge clk);
        rst = 1'b0;
        send(1'b1, 24, fr.size());
        end_frame();
        drain("midreset");
        build(4'd4, 4'd5, 16'd28, 8'h11, 32'h0808_0808, MY_IP, 8, 2, 1'b0);
        run(1'b0);
        drain("after_reset");

        // Randomized frames
        for (int it = 0; it < 30; it++) begin
            eth  = ($urandom_range(0, 9) == 0);
            ver  = ($urandom_range(0, 11) == 0) ? 4'd6 : 4'd4;
            ihl  = ($urandom_range(0, 11) == 0) ? 4'd3 : 4'($urandom_range(5, 7));
            hl   = (ihl < 5) ? 20 : int'(ihl) * 4;
            npay = $urandom_range(0, 12);
            ntl  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, hl - 1) : hl + npay;
            tl   = 16'(ntl);
            bad  = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       dst = 32'hFFFF_FFFF;
                1:       dst = $urandom;
                default: dst = MY_IP;
            endcase
            build(ver, ihl, tl, 8'($urandom_range(0, 255)), $urandom, dst, npay,
                  $urandom_range(0, 6), bad);
            if ($urandom_range(0, 5) == 0) begin
                cut = $urandom_range(1, fr.size());
                while (fr.size() > cut) void'(fr.pop_back());
            end
            run(eth);
            drain("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
